// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add multiply and restoring divide.
// Stalls the pipeline while busy and pulses DONE for one cycle with the result.
module muldiv_sequencer (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic [5:0]  SELECT,
  input  logic [31:0] DATA1,
  input  logic [31:0] DATA2,
  input  logic        FLUSH,
  output logic        STALL,
  output logic        DONE,
  output logic [31:0] RESULT
);

  typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_FIX, ST_DONE} state_t;

  state_t      state;
  logic [5:0]  cnt;
  logic [2:0]  funct3;
  logic [63:0] acc;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic        neg;

  logic [2:0]  in_f3;
  logic        is_md, accept, in_div, s1, s2, div_zero, ovf, fast;
  logic [31:0] fast_res, fix_res;
  logic [32:0] mul_sum;
  logic [33:0] div_diff;
  logic [63:0] prod;

  function automatic logic [31:0] magnitude(input logic signed [31:0] v, input logic take_sign);
    return (take_sign && v[31]) ? 32'(-v) : 32'(v);
  endfunction

  function automatic logic [31:0] apply_sign(input logic [31:0] v, input logic make_neg);
    return make_neg ? (~v + 32'd1) : v;
  endfunction

  assign in_f3    = SELECT[2:0];
  assign is_md    = (SELECT[5:3] == 3'b001);
  assign accept   = (state == ST_IDLE) && START && is_md && !FLUSH;
  assign in_div   = in_f3[2];
  assign s1       = DATA1[31] && (in_f3 == 3'b001 || in_f3 == 3'b010 ||
                                  in_f3 == 3'b100 || in_f3 == 3'b110);
  assign s2       = DATA2[31] && (in_f3 == 3'b001 || in_f3 == 3'b100 || in_f3 == 3'b110);
  assign div_zero = (DATA2 == 32'h0);
  assign ovf      = (in_f3 == 3'b100 || in_f3 == 3'b110) &&
                    (DATA1 == 32'h8000_0000) && (DATA2 == 32'hFFFF_FFFF);
  assign fast     = in_div && (div_zero || ovf);
  // funct3[1] distinguishes REM/REMU from DIV/DIVU
  assign fast_res = div_zero ? (in_f3[1] ? DATA1 : 32'hFFFF_FFFF)
                             : (in_f3[1] ? 32'h0 : 32'h8000_0000);

  assign mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, a_mag} : 33'd0);
  assign div_diff = {1'b0, acc[63:31]} - {2'b00, b_mag};

  always_comb begin
    prod = neg ? (~acc + 64'd1) : acc;
    case (funct3)
      3'b000:                 fix_res = prod[31:0];
      3'b001, 3'b010, 3'b011: fix_res = prod[63:32];
      3'b100, 3'b101:         fix_res = apply_sign(acc[31:0], neg);
      default:                fix_res = apply_sign(acc[63:32], neg);
    endcase
  end

  assign STALL = accept || (state == ST_CALC) || (state == ST_FIX);
  assign DONE  = (state == ST_DONE);

  // Control: state, counter and the architecturally visible result
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= ST_IDLE;
      cnt    <= 6'd0;
      RESULT <= 32'h0;
    end else if (FLUSH) begin
      state <= ST_IDLE;
      cnt   <= 6'd0;
    end else begin
      case (state)
        ST_IDLE: if (accept) begin
          cnt <= 6'd0;
          if (fast) begin
            RESULT <= fast_res;
            state  <= ST_DONE;
          end else begin
            state <= ST_CALC;
          end
        end
        ST_CALC: begin
          cnt <= cnt + 6'd1;
          if (cnt == 6'd31) state <= ST_FIX;
        end
        ST_FIX: begin
          RESULT <= fix_res;
          state  <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Datapath: acc holds {upper, multiplier} for multiply and {remainder, quotient} for divide
  always_ff @(posedge CLK) begin
    if (accept) begin
      funct3 <= in_f3;
      a_mag  <= magnitude(DATA1, s1);
      b_mag  <= magnitude(DATA2, s2);
      neg    <= (in_f3[2] && in_f3[1]) ? s1 : (s1 ^ s2);
      acc    <= {32'h0, in_div ? magnitude(DATA1, s1) : magnitude(DATA2, s2)};
    end else if (state == ST_CALC) begin
      if (funct3[2]) begin
        if (!div_diff[33]) acc <= {div_diff[31:0], acc[30:0], 1'b1};
        else               acc <= {acc[62:0], 1'b0};
      end else begin
        acc <= {mul_sum, acc[31:1]};
      end
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: results queued at issue, compared on DONE.
module tb_muldiv_sequencer;

  logic        CLK = 1'b0;
  logic        RESET, START, FLUSH;
  logic [5:0]  SELECT;
  logic [31:0] DATA1, DATA2;
  logic        STALL, DONE;
  logic [31:0] RESULT;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_exp;

  muldiv_sequencer dut (
    .CLK(CLK), .RESET(RESET), .START(START), .SELECT(SELECT),
    .DATA1(DATA1), .DATA2(DATA2), .FLUSH(FLUSH),
    .STALL(STALL), .DONE(DONE), .RESULT(RESULT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa, sb, ua, r;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    up = {32'h0, a} * {32'h0, b};
    case (f)
      3'd0: begin r = sa * sb; return r[31:0]; end
      3'd1: begin r = sa * sb; return r[63:32]; end
      3'd2: begin r = sa * longint'({32'h0, b}); return r[63:32]; end
      3'd3: return up[63:32];
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        r = sa / sb; return r[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        r = sa % sb; return r[31:0];
      end
      default: begin
        if (b == 0) return a;
        r = ua % longint'({32'h0, b}); return r[31:0];
      end
    endcase
  endfunction

  always @(negedge CLK) begin
    if (DONE) begin
      if (exp_q.size() == 0) check("unexpected_done", {31'h0, DONE}, 32'h0);
      else check("result", RESULT, exp_q.pop_front());
    end
  end

  task automatic run_op(input logic [5:0] sel, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_lat, input bit poke);
    int lat, stalls;
    @(negedge CLK);
    START = 1'b1; SELECT = sel; DATA1 = a; DATA2 = b;
    exp_q.push_back(exp);
    last_exp = exp;
    #1 stalls = STALL ? 1 : 0;
    @(posedge CLK); #1;
    START = 1'b0; DATA1 = $urandom; DATA2 = $urandom; SELECT = 6'($urandom);
    lat = 1;
    while (!DONE && lat < 100) begin
      if (STALL) stalls++;
      START  = poke && lat >= 3 && lat < 10;
      SELECT = poke ? 6'b001000 : SELECT;
      @(posedge CLK); #1;
      lat++;
    end
    START = 1'b0;
    check("latency", 32'(lat), 32'(exp_lat));
    check("stall_cycles", 32'(stalls), 32'(exp_lat == 1 ? 1 : 34));
    check("stall_in_done", {31'h0, STALL}, 32'h0);
    if (!DONE && exp_q.size() > 0) void'(exp_q.pop_front());
    @(posedge CLK); #1;
  endtask

  initial begin
    RESET = 1'b1; START = 1'b0; FLUSH = 1'b0; SELECT = 6'h0; DATA1 = 32'h0; DATA2 = 32'h0;
    repeat (3) @(posedge CLK);
    #1;
    check("reset_result", RESULT, 32'h0);
    check("reset_done", {31'h0, DONE}, 32'h0);
    check("reset_stall", {31'h0, STALL}, 32'h0);
    RESET = 1'b0;
    last_exp = 32'h0;

    run_op(6'b001000, 32'd7, 32'd6, 32'd42, 34, 0);
    run_op(6'b001001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 34, 0);
    run_op(6'b001011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 0);
    run_op(6'b001010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 0);
    run_op(6'b001100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 0);
    run_op(6'b001110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 0);
    run_op(6'b001101, 32'd100, 32'd7, 32'd14, 34, 0);
    run_op(6'b001111, 32'd100, 32'd7, 32'd2, 34, 0);
    run_op(6'b001110, 32'd7, 32'hFFFF_FFFE, 32'd1, 34, 0);
    run_op(6'b001101, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 34, 0);

    run_op(6'b001100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0);
    run_op(6'b001111, 32'd5, 32'd0, 32'd5, 1, 0);
    run_op(6'b001100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
    run_op(6'b001110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1, 0);

    // Non-M ALU op must be ignored
    @(negedge CLK);
    START = 1'b1; SELECT = 6'b000000; DATA1 = 32'd3; DATA2 = 32'd4;
    #1 check("add_stall", {31'h0, STALL}, 32'h0);
    @(posedge CLK); #1;
    check("add_stall_next", {31'h0, STALL}, 32'h0);
    check("add_no_done", {31'h0, DONE}, 32'h0);
    START = 1'b0;

    // START pulses during CALC must not disturb the result
    run_op(6'b001000, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 34, 1);

    // Flush mid-DIVU
    @(negedge CLK);
    START = 1'b1; SELECT = 6'b001101; DATA1 = 32'd1000; DATA2 = 32'd3;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (9) @(posedge CLK);
    #1 FLUSH = 1'b1;
    check("flush_stall_before", {31'h0, STALL}, 32'h1);
    @(posedge CLK); #1;
    FLUSH = 1'b0;
    check("flush_stall", {31'h0, STALL}, 32'h0);
    check("flush_done", {31'h0, DONE}, 32'h0);
    check("flush_result", RESULT, last_exp);
    repeat (40) @(posedge CLK);
    #1 check("flush_result_later", RESULT, last_exp);
    run_op(6'b001000, 32'd123, 32'd456, 32'd56088, 34, 0);

    for (int i = 0; i < 6; i++) begin
      logic [2:0]  f;
      logic [31:0] a, b;
      f = 3'($urandom_range(7));
      a = $urandom;
      b = $urandom;
      if (b == 32'h0) b = 32'd1;
      if (b == 32'hFFFF_FFFF) b = 32'd9;
      run_op({3'b001, f}, a, b, ref_model(f, a, b), 34, 0);
    end

    // Reset mid-MUL
    @(negedge CLK);
    START = 1'b1; SELECT = 6'b001000; DATA1 = 32'd9; DATA2 = 32'd9;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (19) @(posedge CLK);
    #1 RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    check("rst_mid_result", RESULT, 32'h0);
    check("rst_mid_done", {31'h0, DONE}, 32'h0);
    check("rst_mid_stall", {31'h0, STALL}, 32'h0);
    repeat (20) @(posedge CLK);
    run_op(6'b001011, 32'd65536, 32'd65536, 32'd1, 34, 0);

    repeat (3) @(posedge CLK);
    #1 check("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
